// File: rtl/gobou_ctrl.sv
// gobou_ctrl: fully-connected layer sequencer for one gobou_core.
// Walks neurons one at a time, issues bias/weight/input addresses and
// replays the issue events through registered delay lines so every core
// strobe lands in step with the memory read latency.
module gobou_ctrl #(
    parameter int CWIDTH     = 12,
    parameter int IN_AWIDTH  = 12,
    parameter int W_AWIDTH   = 16,
    parameter int OUT_AWIDTH = 12,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  xrst,
    input  logic                  req,
    input  logic [CWIDTH-1:0]     total_in,
    input  logic [CWIDTH-1:0]     total_out,
    input  logic [IN_AWIDTH-1:0]  in_base,
    input  logic [W_AWIDTH-1:0]   w_base,
    input  logic [OUT_AWIDTH-1:0] out_base,
    output logic                  busy,
    output logic                  ack,
    output logic [IN_AWIDTH-1:0]  in_addr,
    output logic [W_AWIDTH-1:0]   w_addr,
    output logic [OUT_AWIDTH-1:0] out_addr,
    output logic                  out_we,
    output logic                  accum_rst,
    output logic                  accum_we,
    output logic                  mac_oe,
    output logic                  breg_we,
    output logic                  bias_oe,
    output logic                  relu_oe
);

    typedef enum logic [2:0] {IDLE, BIAS, ACC, DRAIN, DONE} state_t;

    state_t                  state;
    logic [CWIDTH-1:0]       tin;
    logic [CWIDTH-1:0]       tout;
    logic [CWIDTH-1:0]       idx;
    logic [CWIDTH-1:0]       nrn;
    logic [IN_AWIDTH-1:0]    in_base_q;
    logic [OUT_AWIDTH-1:0]   out_base_q;
    logic [W_AWIDTH-1:0]     w_ptr;
    logic [3:0]              dcnt;

    // Issue events, true in the very cycle the matching address is on the bus.
    logic                    bias_iss;
    logic                    acc_iss;
    logic                    end_iss;

    // Delay lines: stage k is the event delayed by k+1 cycles.
    logic [MEM_LAT-1:0]      bias_d;
    logic [MEM_LAT-1:0]      acc_d;
    logic [MEM_LAT+3:0]      end_d;

    logic [CWIDTH-1:0]       idx_inc;
    logic [CWIDTH-1:0]       idx_inc2;
    logic                    acc_last;
    logic                    nrn_last;
    logic                    drain_end;

    // idx never exceeds tin-1, so idx+2 only matters when it does not wrap.
    assign idx_inc   = idx + CWIDTH'(1);
    assign idx_inc2  = idx + CWIDTH'(2);
    assign acc_last  = (idx_inc == tin);
    assign nrn_last  = (nrn == tout - CWIDTH'(1));
    assign drain_end = (dcnt == 4'(MEM_LAT + 3));

    // Layer FSM with registered addresses, busy/ack and issue events.
    always_ff @(posedge clk) begin
        if (xrst) begin
            state      <= IDLE;
            tin        <= '0;
            tout       <= '0;
            idx        <= '0;
            nrn        <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            w_ptr      <= '0;
            dcnt       <= '0;
            busy       <= 1'b0;
            ack        <= 1'b0;
            in_addr    <= '0;
            w_addr     <= '0;
            bias_iss   <= 1'b0;
            acc_iss    <= 1'b0;
            end_iss    <= 1'b0;
        end else begin
            bias_iss <= 1'b0;
            acc_iss  <= 1'b0;
            end_iss  <= 1'b0;
            ack      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        tin        <= total_in;
                        tout       <= total_out;
                        in_base_q  <= in_base;
                        out_base_q <= out_base;
                        nrn        <= '0;
                        if (total_out == '0) begin
                            state <= DONE;
                            ack   <= 1'b1;
                            w_ptr <= w_base;
                        end else begin
                            state    <= BIAS;
                            busy     <= 1'b1;
                            w_addr   <= w_base;
                            w_ptr    <= w_base + W_AWIDTH'(1);
                            bias_iss <= 1'b1;
                            end_iss  <= (total_in == '0);
                        end
                    end
                end
                BIAS: begin
                    if (tin == '0) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else begin
                        state   <= ACC;
                        idx     <= '0;
                        in_addr <= in_base_q;
                        w_addr  <= w_ptr;
                        w_ptr   <= w_ptr + W_AWIDTH'(1);
                        acc_iss <= 1'b1;
                        end_iss <= (tin == CWIDTH'(1));
                    end
                end
                ACC: begin
                    if (acc_last) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else begin
                        idx     <= idx_inc;
                        in_addr <= in_base_q + IN_AWIDTH'(idx_inc);
                        w_addr  <= w_ptr;
                        w_ptr   <= w_ptr + W_AWIDTH'(1);
                        acc_iss <= 1'b1;
                        end_iss <= (idx_inc2 == tin);
                    end
                end
                DRAIN: begin
                    if (drain_end) begin
                        if (nrn_last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            ack   <= 1'b1;
                        end else begin
                            state    <= BIAS;
                            nrn      <= nrn + CWIDTH'(1);
                            w_addr   <= w_ptr;
                            w_ptr    <= w_ptr + W_AWIDTH'(1);
                            bias_iss <= 1'b1;
                            end_iss  <= (tin == '0);
                        end
                    end else begin
                        dcnt <= dcnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobe delay lines; outputs are taken straight from flop stages.
    always_ff @(posedge clk) begin
        if (xrst) begin
            bias_d <= '0;
            acc_d  <= '0;
            end_d  <= '0;
        end else begin
            bias_d[0] <= bias_iss;
            acc_d[0]  <= acc_iss;
            end_d[0]  <= end_iss;
            for (int k = 1; k < MEM_LAT; k++) begin
                bias_d[k] <= bias_d[k-1];
                acc_d[k]  <= acc_d[k-1];
            end
            for (int k = 1; k < MEM_LAT + 4; k++) begin
                end_d[k] <= end_d[k-1];
            end
        end
    end

    // Output address is loaded one cycle ahead of out_we; nrn is stable in DRAIN.
    always_ff @(posedge clk) begin
        if (xrst) begin
            out_addr <= '0;
        end else if (end_d[MEM_LAT+2]) begin
            out_addr <= out_base_q + OUT_AWIDTH'(nrn);
        end
    end

    assign breg_we   = bias_d[MEM_LAT-1];
    assign accum_rst = bias_d[MEM_LAT-1];
    assign accum_we  = acc_d[MEM_LAT-1];
    assign mac_oe    = end_d[MEM_LAT];
    assign bias_oe   = end_d[MEM_LAT+1];
    assign relu_oe   = end_d[MEM_LAT+2];
    assign out_we    = end_d[MEM_LAT+3];

endmodule
